ctrl_unit: RTL and testbench

CTRL_UNIT -- requirements
Module: ctrl_unit

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/ctrl_decode.sv | 26 ++
 rtl/ctrl_unit.sv | 169 ++++++++++++++++
 tb/tb_ctrl_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the control unit: opcodes, ALU functions, PC ops, FSM states, decode payload.
// The ERR state exists only when CTRL_TIMEOUT_EN is defined.
package ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned FUNC_W  = 3;
    localparam int unsigned PCC_W   = 2;
    localparam int unsigned REG_N   = 4;
    localparam int unsigned RIDX_W  = 2;
    localparam int unsigned OFF_W   = 8;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h1;
    localparam logic [OP_W-1:0] OP_MVI  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h4;
    localparam logic [OP_W-1:0] OP_AND  = 4'h5;
    localparam logic [OP_W-1:0] OP_OR   = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [FUNC_W-1:0] ALU_PASS = 3'b000;
    localparam logic [FUNC_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [FUNC_W-1:0] ALU_SUB  = 3'b010;
    localparam logic [FUNC_W-1:0] ALU_AND  = 3'b011;
    localparam logic [FUNC_W-1:0] ALU_OR   = 3'b100;
    localparam logic [FUNC_W-1:0] ALU_XOR  = 3'b101;

    localparam logic [PCC_W-1:0] PC_HOLD = 2'b00;
    localparam logic [PCC_W-1:0] PC_INC  = 2'b01;
    localparam logic [PCC_W-1:0] PC_REL  = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WAIT,
        ST_WB,
        ST_PCUPD,
        ST_HALT
`ifdef CTRL_TIMEOUT_EN
        , ST_ERR
`endif
    } state_e;

    typedef struct packed {
        logic              is_alu;
        logic              is_jmp;
        logic              is_halt;
        logic              alu_in_sel;
        logic [FUNC_W-1:0] alu_func;
    } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control decode; undefined opcodes decode as NOP (all fields zero).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output dec_t            dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_MOV:  begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_PASS; end
            OP_MVI:  begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_PASS; dec_o.alu_in_sel = 1'b1; end
            OP_ADD:  begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_ADD;  end
            OP_SUB:  begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_SUB;  end
            OP_AND:  begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_AND;  end
            OP_OR:   begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_OR;   end
            OP_XOR:  begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_XOR;  end
            OP_ADDI: begin dec_o.is_alu = 1'b1; dec_o.alu_func = ALU_ADD;  dec_o.alu_in_sel = 1'b1; end
            OP_JMP:  dec_o.is_jmp  = 1'b1;
            OP_HALT: dec_o.is_halt = 1'b1;
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle instruction control FSM: fetch, decode, datapath handshake, writeback, PC update.
// Optional WAIT-state watchdog enabled by defining CTRL_TIMEOUT_EN.
module ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned WD_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_req,
    input  logic               en_out,
    output logic               en_pc,
    output logic [PCC_W-1:0]   pc_ctrl,
    output logic [OFF_W-1:0]   offset,
    output logic               en_in,
    output logic [REG_N-1:0]   reg_en,
    output logic [RIDX_W-1:0]  rd,
    output logic [RIDX_W-1:0]  rs,
    output logic               alu_in_sel,
    output logic [FUNC_W-1:0]  alu_func,
    output logic               halted,
    output logic               err
);

    state_e              state_q;
    logic [INSTR_W-1:0]  ir_q;
    logic                instr_req_q;
    logic                en_pc_q;
    logic [PCC_W-1:0]    pc_ctrl_q;
    logic [OFF_W-1:0]    offset_q;
    logic                en_in_q;
    logic [REG_N-1:0]    reg_en_q;
    logic [RIDX_W-1:0]   rd_q;
    logic [RIDX_W-1:0]   rs_q;
    logic                alu_in_sel_q;
    logic [FUNC_W-1:0]   alu_func_q;
    logic                halted_q;
    dec_t                dec;

    ctrl_decode u_decode (
        .opcode_i (ir_q[15:12]),
        .dec_o    (dec)
    );

`ifdef CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    assign err = err_q;
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^WD_LIMIT;
    assign err = 1'b0;
`endif

    // Outputs are set on the edge entering the state that owns them and cleared on leaving it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ir_q         <= '0;
            instr_req_q  <= 1'b0;
            en_pc_q      <= 1'b0;
            pc_ctrl_q    <= PC_HOLD;
            offset_q     <= '0;
            en_in_q      <= 1'b0;
            reg_en_q     <= '0;
            rd_q         <= '0;
            rs_q         <= '0;
            alu_in_sel_q <= 1'b0;
            alu_func_q   <= ALU_PASS;
            halted_q     <= 1'b0;
`ifdef CTRL_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q     <= ST_FETCH;
                        instr_req_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir_q        <= instr_in;
                        instr_req_q <= 1'b0;
                        state_q     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    rd_q         <= ir_q[11:10];
                    rs_q         <= ir_q[9:8];
                    offset_q     <= ir_q[7:0];
                    alu_func_q   <= dec.alu_func;
                    alu_in_sel_q <= dec.alu_in_sel;
                    if (dec.is_halt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (dec.is_alu) begin
                        state_q <= ST_EXEC;
                        en_in_q <= 1'b1;
                    end else begin
                        state_q   <= ST_PCUPD;
                        en_pc_q   <= 1'b1;
                        pc_ctrl_q <= dec.is_jmp ? PC_REL : PC_INC;
                    end
                end
                ST_EXEC: begin
                    en_in_q <= 1'b0;
                    state_q <= ST_WAIT;
`ifdef CTRL_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                ST_WAIT: begin
                    if (en_out) begin
                        state_q  <= ST_WB;
                        reg_en_q <= 4'b0001 << rd_q;
`ifdef CTRL_TIMEOUT_EN
                    end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
`endif
                    end
                end
                ST_WB: begin
                    reg_en_q  <= '0;
                    state_q   <= ST_PCUPD;
                    en_pc_q   <= 1'b1;
                    pc_ctrl_q <= PC_INC;
                end
                ST_PCUPD: begin
                    en_pc_q   <= 1'b0;
                    pc_ctrl_q <= PC_HOLD;
                    if (run) begin
                        state_q     <= ST_FETCH;
                        instr_req_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
`ifdef CTRL_TIMEOUT_EN
                ST_ERR:  state_q <= ST_ERR;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_req  = instr_req_q;
    assign en_pc      = en_pc_q;
    assign pc_ctrl    = pc_ctrl_q;
    assign offset     = offset_q;
    assign en_in      = en_in_q;
    assign reg_en     = reg_en_q;
    assign rd         = rd_q;
    assign rs         = rs_q;
    assign alu_in_sel = alu_in_sel_q;
    assign alu_func   = alu_func_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: vector table with scoreboard queue plus reset, run-drop,
// watchdog and HALT sequences. Watchdog expectation follows CTRL_TIMEOUT_EN.
module tb_ctrl_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_req;
    logic        en_out;
    logic        en_pc;
    logic [1:0]  pc_ctrl;
    logic [7:0]  offset;
    logic        en_in;
    logic [3:0]  reg_en;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic        alu_in_sel;
    logic [2:0]  alu_func;
    logic        halted;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] instr;
        int          dly;
        int          gap;
        bit          spur;
        bit          drop_run;
        bit          alu;
        logic [3:0]  reg_en;
        logic [2:0]  func;
        logic        sel;
        logic [1:0]  pc;
    } vec_t;

    typedef struct {
        int         lat;
        int         en_in_n;
        logic [3:0] reg_en;
        int         reg_en_n;
        logic [1:0] pc;
        logic [7:0] off;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [2:0] func;
        logic       sel;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    ctrl_unit #(.WD_LIMIT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .en_out      (en_out),
        .en_pc       (en_pc),
        .pc_ctrl     (pc_ctrl),
        .offset      (offset),
        .en_in       (en_in),
        .reg_en      (reg_en),
        .rd          (rd),
        .rs          (rs),
        .alu_in_sel  (alu_in_sel),
        .alu_func    (alu_func),
        .halted      (halted),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got stalled simulation expected completion");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = instr_req;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t       e;
        exp_t       p;
        bit         ok;
        bit         done;
        int         lat;
        int         since;
        int         en_in_n;
        int         reg_en_n;
        logic [3:0] reg_en_or;
        wait_req(ok);
        chk($sformatf("v%0d_fetch_req", idx), 32'(ok), 32'd1);
        if (!ok) return;
        for (int g = 0; g < v.gap; g++) begin
            instr_in    = 16'hF000;
            instr_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_req_held", idx), 32'(instr_req), 32'd1);
        end
        e.lat      = v.alu ? 4 + v.dly : 2;
        e.en_in_n  = v.alu ? 1 : 0;
        e.reg_en   = v.reg_en;
        e.reg_en_n = v.alu ? 1 : 0;
        e.pc       = v.pc;
        e.off      = v.instr[7:0];
        e.rd       = v.instr[11:10];
        e.rs       = v.instr[9:8];
        e.func     = v.func;
        e.sel      = v.sel;
        sb_q.push_back(e);
        instr_in    = v.instr;
        instr_valid = 1'b1;
        lat = 0; since = -1; en_in_n = 0; reg_en_n = 0; reg_en_or = '0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            instr_in    = '0;
            en_out      = 1'b0;
            lat++;
            if (en_in) begin
                en_in_n++;
                since = 0;
                if (v.spur) en_out = 1'b1;
                if (v.drop_run) run = 1'b0;
                chk($sformatf("v%0d_func_exec", idx), 32'(alu_func), 32'(e.func));
                chk($sformatf("v%0d_sel_exec", idx), 32'(alu_in_sel), 32'(e.sel));
            end else if (since >= 0) begin
                since++;
                if (since == v.dly) en_out = 1'b1;
            end
            if (reg_en != 4'b0000) begin
                reg_en_n++;
                reg_en_or = reg_en_or | reg_en;
            end
            if (en_pc) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", idx), 32'd0, 32'd1);
                end else begin
                    p = sb_q.pop_front();
                    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(p.lat));
                    chk($sformatf("v%0d_en_in_pulses", idx), 32'(en_in_n), 32'(p.en_in_n));
                    chk($sformatf("v%0d_reg_en", idx), 32'(reg_en_or), 32'(p.reg_en));
                    chk($sformatf("v%0d_reg_en_cycles", idx), 32'(reg_en_n), 32'(p.reg_en_n));
                    chk($sformatf("v%0d_pc_ctrl", idx), 32'(pc_ctrl), 32'(p.pc));
                    chk($sformatf("v%0d_offset", idx), 32'(offset), 32'(p.off));
                    chk($sformatf("v%0d_rd", idx), 32'(rd), 32'(p.rd));
                    chk($sformatf("v%0d_rs", idx), 32'(rs), 32'(p.rs));
                    chk($sformatf("v%0d_alu_func", idx), 32'(alu_func), 32'(p.func));
                    chk($sformatf("v%0d_alu_in_sel", idx), 32'(alu_in_sel), 32'(p.sel));
                end
            end
        end
        if (!done) begin
            chk($sformatf("v%0d_en_pc_timeout", idx), 32'd0, 32'd1);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            return;
        end
        en_out = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_en_pc_drop", idx), 32'(en_pc), 32'd0);
        chk($sformatf("v%0d_pc_ctrl_hold", idx), 32'(pc_ctrl), 32'd0);
        chk($sformatf("v%0d_next_req", idx), 32'(instr_req), 32'(!v.drop_run));
    endtask

    initial begin
        bit         ok;
        int         bad;
        int         first_err;
        logic [3:0] strobes;

        rst = 1'b1; run = 1'b0; instr_in = '0; instr_valid = 1'b0; en_out = 1'b0;

        //               instr    dly gap spr drp alu reg_en   func    sel pc
        vecs[0]  = '{16'h3600, 3, 0, 0, 0, 1, 4'b0010, 3'b001, 1'b0, 2'b01};
        vecs[1]  = '{16'h2C5A, 1, 0, 0, 0, 1, 4'b1000, 3'b000, 1'b1, 2'b01};
        vecs[2]  = '{16'h90FE, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 1'b0, 2'b10};
        vecs[3]  = '{16'h4B11, 2, 2, 1, 0, 1, 4'b0100, 3'b010, 1'b0, 2'b01};
        vecs[4]  = '{16'h5033, 1, 0, 0, 0, 1, 4'b0001, 3'b011, 1'b0, 2'b01};
        vecs[5]  = '{16'h6E00, 4, 0, 0, 0, 1, 4'b1000, 3'b100, 1'b0, 2'b01};
        vecs[6]  = '{16'h7500, 1, 1, 0, 0, 1, 4'b0010, 3'b101, 1'b0, 2'b01};
        vecs[7]  = '{16'h8D7F, 2, 0, 0, 0, 1, 4'b1000, 3'b001, 1'b1, 2'b01};
        vecs[8]  = '{16'h1900, 1, 0, 0, 0, 1, 4'b0100, 3'b000, 1'b0, 2'b01};
        vecs[9]  = '{16'h0ABC, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 1'b0, 2'b01};
        vecs[10] = '{16'hC123, 0, 0, 0, 0, 0, 4'b0000, 3'b000, 1'b0, 2'b01};
        vecs[11] = '{16'h1400, 2, 0, 0, 1, 1, 4'b0010, 3'b000, 1'b0, 2'b01};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_instr_req", 32'(instr_req), 32'd0);
        chk("rst_strobes", 32'({en_pc, en_in, reg_en, pc_ctrl}), 32'd0);
        chk("rst_fields", 32'({offset, rd, rs, alu_in_sel, alu_func}), 32'd0);
        chk("rst_flags", 32'({halted, err}), 32'd0);

        rst = 1'b0;
        run = 1'b1;
        #1;
        chk("no_fetch_before_edge", 32'(instr_req), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Run dropped during the last vector: controller must sit in IDLE, then resume
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (instr_req) bad++;
        end
        chk("idle_no_req", 32'(bad), 32'd0);
        run = 1'b1;
        @(negedge clk);
        chk("restart_req", 32'(instr_req), 32'd1);

        // Reset asserted mid-cycle while in WAIT
        instr_in = 16'h2C5A; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_offset", 32'(offset), 32'h5A);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_all", 32'({instr_req, en_pc, pc_ctrl, offset, en_in, reg_en, rd, rs,
                                  alu_in_sel, alu_func, halted, err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        en_out = 1'b1;
        @(negedge clk);
        en_out = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (reg_en != 4'b0000 || en_pc || instr_req) bad++;
        end
        chk("spurious_en_out", 32'(bad), 32'd0);

        // Datapath never answers
        run = 1'b1;
        wait_req(ok);
        chk("wd_fetch_req", 32'(ok), 32'd1);
        instr_in = 16'h3600; instr_valid = 1'b1;
        first_err = 0;
        strobes   = '0;
        for (int l = 1; l <= 24; l++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            if (err && first_err == 0) first_err = l;
            strobes = strobes | reg_en | {3'b000, en_pc};
        end
`ifdef CTRL_TIMEOUT_EN
        chk("wd_err_cycle", 32'(first_err), 32'd19);
`else
        chk("wd_err_never", 32'(first_err), 32'd0);
`endif
        chk("wd_no_strobes", 32'(strobes), 32'd0);
        chk("wd_no_refetch", 32'(instr_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("wd_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // HALT followed by more valid instructions
        wait_req(ok);
        chk("halt_fetch_req", 32'(ok), 32'd1);
        instr_in = 16'hF000; instr_valid = 1'b1;
        @(negedge clk);
        instr_in = 16'h3600;
        bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k >= 2 && (!halted || instr_req || en_in || en_pc || reg_en != 4'b0000 || err)) bad++;
        end
        instr_valid = 1'b0;
        chk("halt_hold", 32'(bad), 32'd0);
        chk("halted_flag", 32'(halted), 32'd1);
        rst = 1'b1;
        #1;
        chk("halt_rst_clear", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
